// File: rtl/prf_trig_gen.sv
// PRF trigger source: internal periodic (continuous/single/burst) or external
// synchronised trigger with holdoff, feeding the trigwave edge detector.
module prf_trig_gen #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16,
    parameter int TRIG_HI  = 8
) (
    input  logic                i_clk100M,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [1:0]          i_mode,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [CNT_W-1:0]    i_burst,
    input  logic [PERIOD_W-1:0] i_holdoff,
    input  logic                i_ext_trig,
    output logic                o_trig,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_trig_cnt
);

    typedef enum logic [2:0] {IDLE, RUN_HI, RUN_LO, EXT_WAIT, EXT_HI, EXT_HOLD} state_t;

    localparam logic [1:0] M_CONT   = 2'b00;
    localparam logic [1:0] M_SINGLE = 2'b01;
    localparam logic [1:0] M_EXT    = 2'b11;

    localparam logic [PERIOD_W-1:0] MIN_GAP = PERIOD_W'(2 * TRIG_HI);
    localparam logic [PERIOD_W-1:0] HI_LAST = PERIOD_W'(TRIG_HI - 1);
    localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1);
    localparam logic [CNT_W-1:0]    C_ONE   = CNT_W'(1);

    state_t              state, state_nxt;
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] period_q, holdoff_q, per_cnt;
    logic [CNT_W-1:0]    burst_rem;
    logic                stop_pend;
    logic [2:0]          ext_pipe;
    logic                ext_edge;
    logic                rise, done_nxt, start_acc, stop_req;

    assign stop_req = i_stop | stop_pend;

    always_comb begin
        state_nxt = state;
        rise      = 1'b0;
        done_nxt  = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                // stop beats start when both arrive together
                if (i_start && !i_stop) begin
                    start_acc = 1'b1;
                    if (i_mode == M_EXT) begin
                        state_nxt = EXT_WAIT;
                    end else begin
                        state_nxt = RUN_HI;
                        rise      = 1'b1;
                    end
                end
            end
            RUN_HI: begin
                if (per_cnt == HI_LAST) begin
                    if (stop_req || (mode_q != M_CONT && burst_rem == '0)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RUN_LO;
                    end
                end
            end
            RUN_LO: begin
                if (i_stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (per_cnt == period_q - P_ONE) begin
                    state_nxt = RUN_HI;
                    rise      = 1'b1;
                end
            end
            EXT_WAIT: begin
                if (i_stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (ext_edge) begin
                    state_nxt = EXT_HI;
                    rise      = 1'b1;
                end
            end
            EXT_HI: begin
                if (per_cnt == HI_LAST) begin
                    if (stop_req) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = EXT_HOLD;
                    end
                end
            end
            EXT_HOLD: begin
                // edges seen while holding off are discarded, not queued
                if (i_stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (per_cnt == holdoff_q - P_ONE) begin
                    state_nxt = EXT_WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk100M) begin
        if (i_rst) begin
            state      <= IDLE;
            mode_q     <= M_CONT;
            period_q   <= MIN_GAP;
            holdoff_q  <= MIN_GAP;
            burst_rem  <= '0;
            per_cnt    <= '0;
            stop_pend  <= 1'b0;
            ext_pipe   <= '0;
            ext_edge   <= 1'b0;
            o_trig     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_trig_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ext_pipe <= {ext_pipe[1:0], i_ext_trig};
            ext_edge <= ext_pipe[1] & ~ext_pipe[2];
            o_trig   <= (state_nxt == RUN_HI) || (state_nxt == EXT_HI);
            o_busy   <= (state_nxt != IDLE);
            o_done   <= done_nxt;

            if (state_nxt == IDLE)
                stop_pend <= 1'b0;
            else if (i_stop)
                stop_pend <= 1'b1;

            if (rise)
                per_cnt <= '0;
            else if (state == RUN_HI || state == RUN_LO || state == EXT_HI || state == EXT_HOLD)
                per_cnt <= per_cnt + P_ONE;

            if (start_acc) begin
                mode_q    <= i_mode;
                period_q  <= (i_period  < MIN_GAP) ? MIN_GAP : i_period;
                holdoff_q <= (i_holdoff < MIN_GAP) ? MIN_GAP : i_holdoff;
                // the start edge itself issues the first internal trigger
                if (i_mode == M_SINGLE || i_burst == '0)
                    burst_rem <= '0;
                else
                    burst_rem <= i_burst - C_ONE;
                o_trig_cnt <= rise ? C_ONE : '0;
            end else if (rise) begin
                if (burst_rem != '0)
                    burst_rem <= burst_rem - C_ONE;
                o_trig_cnt <= o_trig_cnt + C_ONE;
            end
        end
    end

endmodule

// File: tb/tb_prf_trig_gen.sv
// Directed bench for prf_trig_gen: table of internal-mode runs plus hand
// sequences for reset, stop mid-pulse, start/stop collision and external mode.
module tb_prf_trig_gen;

    localparam int TRIG_HI = 8;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_stop, i_ext_trig;
    logic [1:0]  i_mode;
    logic [23:0] i_period, i_holdoff;
    logic [15:0] i_burst;
    logic        o_trig, o_busy, o_done;
    logic [15:0] o_trig_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] mode;
        int period;
        int burst;
        int cycles;
        bit poke;
        int rises;
        int gap;
        int done_k;
        int cnt;
    } row_t;

    row_t tbl [7];

    prf_trig_gen dut (
        .i_clk100M (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_mode    (i_mode),
        .i_period  (i_period),
        .i_burst   (i_burst),
        .i_holdoff (i_holdoff),
        .i_ext_trig(i_ext_trig),
        .o_trig    (o_trig),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_trig_cnt(o_trig_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic stop_and_drain(input string nm);
        int w;
        w = 0;
        i_stop = 1'b1;
        while (o_busy && w < 100) begin
            tick();
            w++;
        end
        i_stop = 1'b0;
        chk({nm, " drain"}, int'(o_busy), 0);
        tick();
    endtask

    task automatic run_row(input int idx, input row_t r);
        int rises, first, second, done_k, dones, hi, hi_bad;
        bit prev;
        string nm;
        nm = $sformatf("row%0d", idx);
        i_mode   = r.mode;
        i_period = 24'(r.period);
        i_burst  = 16'(r.burst);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        // changes after the start must be ignored
        i_mode   = 2'b11;
        i_period = 24'd7;
        i_burst  = 16'd1;
        rises = 0; first = -1; second = -1; done_k = -1; dones = 0; hi = 0; hi_bad = 0;
        prev = 1'b0;
        chk({nm, " busy@start"}, int'(o_busy), 1);
        for (int k = 0; k < r.cycles; k++) begin
            if (o_trig && !prev) begin
                rises++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (o_trig) hi++;
            else if (prev) begin
                if (hi != TRIG_HI) hi_bad++;
                hi = 0;
            end
            if (o_done) begin
                dones++;
                if (done_k < 0) done_k = k;
            end
            prev = o_trig;
            i_start = r.poke && (k + 1 == 50);
            tick();
        end
        i_start = 1'b0;
        chk({nm, " rises"}, rises, r.rises);
        chk({nm, " first_rise"}, first, 0);
        if (r.rises > 1) chk({nm, " gap"}, second - first, r.gap);
        chk({nm, " high_len_bad"}, hi_bad, 0);
        chk({nm, " done_edge"}, done_k, r.done_k);
        chk({nm, " done_pulses"}, dones, (r.done_k >= 0) ? 1 : 0);
        chk({nm, " trig_cnt"}, int'(o_trig_cnt), r.cnt);
        chk({nm, " busy_end"}, int'(o_busy), (r.done_k < 0) ? 1 : 0);
        if (o_busy) stop_and_drain(nm);
    endtask

    function automatic bit ext_win(input int k);
        return (k >= 10 && k < 15) || (k >= 30 && k < 35) || (k >= 70 && k < 75);
    endfunction

    initial begin
        int rises, first, second, hi, hi_bad, done_k;
        bit prev;

        //           mode   per   bst cyc  poke rises gap done cnt
        tbl[0] = '{2'b00, 1000, 0, 2010, 1'b0, 3, 1000, -1, 3};
        tbl[1] = '{2'b10, 100,  3, 220,  1'b1, 3, 100, 208, 3};
        tbl[2] = '{2'b01, 50,   7, 60,   1'b0, 1, 0,   8,   1};
        tbl[3] = '{2'b10, 3,    0, 30,   1'b0, 1, 0,   8,   1};
        tbl[4] = '{2'b00, 5,    0, 50,   1'b0, 4, 16,  -1,  4};
        tbl[5] = '{2'b10, 20,   2, 40,   1'b0, 2, 20,  28,  2};
        tbl[6] = '{2'b00, 40,   0, 130,  1'b1, 4, 40,  -1,  4};

        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_ext_trig = 1'b0;
        i_mode = 2'b00; i_period = 24'd1000; i_burst = 16'd0; i_holdoff = 24'd50;
        tick();
        tick();
        chk("reset trig", int'(o_trig), 0);
        chk("reset busy", int'(o_busy), 0);
        chk("reset done", int'(o_done), 0);
        chk("reset cnt", int'(o_trig_cnt), 0);
        i_rst = 1'b0;
        tick();

        // reset during the high phase
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        chk("pre-reset trig", int'(o_trig), 1);
        chk("pre-reset cnt", int'(o_trig_cnt), 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst trig", int'(o_trig), 0);
        chk("midrst busy", int'(o_busy), 0);
        chk("midrst done", int'(o_done), 0);
        chk("midrst cnt", int'(o_trig_cnt), 0);
        tick();

        // start and stop together in idle: nothing starts
        i_start = 1'b1; i_stop = 1'b1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        chk("start+stop busy", int'(o_busy), 0);
        chk("start+stop trig", int'(o_trig), 0);
        tick();
        chk("start+stop done", int'(o_done), 0);

        for (int i = 0; i < 7; i++) run_row(i, tbl[i]);

        // stop raised on the 3rd high cycle of a continuous pulse
        i_mode = 2'b00; i_period = 24'd100; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        rises = 0; hi = 0; done_k = -1; prev = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (o_trig && !prev) rises++;
            if (o_trig) hi++;
            if (o_done && done_k < 0) done_k = k;
            prev = o_trig;
            i_stop = (k == 2);
            tick();
        end
        i_stop = 1'b0;
        chk("stop rises", rises, 1);
        chk("stop high_len", hi, TRIG_HI);
        chk("stop done_edge", done_k, 8);
        chk("stop busy_end", int'(o_busy), 0);
        chk("stop cnt", int'(o_trig_cnt), 1);

        // external mode: raw edges at 10, 30, 70 with holdoff 50
        i_mode = 2'b11; i_holdoff = 24'd50; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("ext trig@start", int'(o_trig), 0);
        chk("ext busy@start", int'(o_busy), 1);
        chk("ext cnt@start", int'(o_trig_cnt), 0);
        rises = 0; first = -1; second = -1; hi = 0; hi_bad = 0; prev = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            i_ext_trig = ext_win(k);
            tick();
            if (o_trig && !prev) begin
                rises++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (o_trig) hi++;
            else if (prev) begin
                if (hi != TRIG_HI) hi_bad++;
                hi = 0;
            end
            prev = o_trig;
        end
        i_ext_trig = 1'b0;
        chk("ext rises", rises, 2);
        chk("ext first", first, 13);
        chk("ext second", second, 73);
        chk("ext high_len_bad", hi_bad, 0);
        chk("ext cnt", int'(o_trig_cnt), 2);
        chk("ext busy", int'(o_busy), 1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("ext stop done", int'(o_done), 1);
        chk("ext stop busy", int'(o_busy), 0);
        tick();
        chk("ext done pulse", int'(o_done), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
